// File: rtl/target_ibi_sched_pkg.sv
// Shared encodings for the target-side IBI scheduler: FSM attempt results and completion status.
package target_ibi_sched_pkg;

  localparam int unsigned AddrWidth = 7;
  localparam int unsigned MdbWidth  = 8;

  typedef enum logic [1:0] {
    ResAck     = 2'b00,
    ResNack    = 2'b01,
    ResArbLost = 2'b10,
    ResRsvd    = 2'b11
  } ibi_result_e;

  typedef enum logic [1:0] {
    StsOk             = 2'b00,
    StsRetryExhausted = 2'b01,
    StsAborted        = 2'b10
  } ibi_status_e;

endpackage

// File: rtl/target_ibi_sched_if.sv
// Request / target-FSM / status handshake bundle of the IBI scheduler.
interface target_ibi_sched_if
  import target_ibi_sched_pkg::*;
#(
  parameter int unsigned RetryWidth = 3
) ();

  logic                  req_valid;
  logic [MdbWidth-1:0]   req_mdb;
  logic                  req_ready;
  logic                  ibi_start;
  logic [AddrWidth-1:0]  ibi_addr;
  logic [MdbWidth-1:0]   ibi_mdb;
  logic                  fsm_done;
  ibi_result_e           fsm_result;
  logic                  status_valid;
  ibi_status_e           status;
  logic [RetryWidth-1:0] retry_cnt;
  logic                  busy;

  // Scheduler side.
  modport slave (
    input  req_valid, req_mdb, fsm_done, fsm_result,
    output req_ready, ibi_start, ibi_addr, ibi_mdb, status_valid, status, retry_cnt, busy
  );

  // TTI queue / target FSM / status consumer side.
  modport master (
    output req_valid, req_mdb, fsm_done, fsm_result,
    input  req_ready, ibi_start, ibi_addr, ibi_mdb, status_valid, status, retry_cnt, busy
  );

endinterface

// File: rtl/target_ibi_sched.sv
// Schedules one in-band interrupt: waits for bus-available, fires the target FSM and retries on
// NACK / lost arbitration until ACK, retry exhaustion or disable.
module target_ibi_sched
  import target_ibi_sched_pkg::*;
#(
  parameter int unsigned RetryWidth = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ibi_enable_i,
  input  logic [RetryWidth-1:0] ibi_retry_num_i,
  input  logic [AddrWidth-1:0]  ibi_addr_i,
  input  logic                  ibi_addr_valid_i,
  input  logic                  bus_available_i,
  target_ibi_sched_if.slave     ibi
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitBus,
    StRequest,
    StWaitResult,
    StReport
  } state_e;

  state_e                state_q, state_d;
  logic [RetryWidth-1:0] cnt_q, cnt_d;
  logic [RetryWidth-1:0] limit_q, limit_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [MdbWidth-1:0]   mdb_q, mdb_d;
  ibi_status_e           status_q, status_d;
  logic                  req_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      limit_q  <= '0;
      addr_q   <= '0;
      mdb_q    <= '0;
      status_q <= StsOk;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      limit_q  <= limit_d;
      addr_q   <= addr_d;
      mdb_q    <= mdb_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    limit_d  = limit_q;
    addr_d   = addr_q;
    mdb_d    = mdb_q;
    status_d = status_q;
    // Gated by rst_ni so the handshake output is also 0 while reset is held.
    req_ready = rst_ni && (state_q == StIdle) && ibi_enable_i && ibi_addr_valid_i;

    unique case (state_q)
      StIdle: begin
        if (req_ready && ibi.req_valid) begin
          addr_d  = ibi_addr_i;
          mdb_d   = ibi.req_mdb;
          limit_d = ibi_retry_num_i;
          cnt_d   = '0;
          state_d = StWaitBus;
        end
      end
      StWaitBus: begin
        if (!ibi_enable_i) begin
          status_d = StsAborted;
          state_d  = StReport;
        end else if (bus_available_i) begin
          state_d = StRequest;
        end
      end
      StRequest: state_d = StWaitResult;
      StWaitResult: begin
        // Enable is deliberately not looked at here: an attempt on the bus must finish first.
        if (ibi.fsm_done) begin
          case (ibi.fsm_result)
            ResAck: begin
              status_d = StsOk;
              state_d  = StReport;
            end
            ResArbLost: state_d = StWaitBus;
            default: begin
              if (cnt_q < limit_q) begin
                cnt_d   = cnt_q + RetryWidth'(1);
                state_d = StWaitBus;
              end else begin
                status_d = StsRetryExhausted;
                state_d  = StReport;
              end
            end
          endcase
        end
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign ibi.req_ready    = req_ready;
  assign ibi.ibi_start    = (state_q == StRequest);
  assign ibi.ibi_addr     = addr_q;
  assign ibi.ibi_mdb      = mdb_q;
  assign ibi.status_valid = (state_q == StReport);
  assign ibi.status       = status_q;
  assign ibi.retry_cnt    = cnt_q;
  assign ibi.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_target_ibi_sched.sv
// Randomized self-checking bench for target_ibi_sched with a result-sequence reference model.
module tb_target_ibi_sched;
  import target_ibi_sched_pkg::*;

  typedef ibi_result_e res_q_t [$];

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       ibi_enable = 1'b0;
  logic [2:0] ibi_retry_num = '0;
  logic [6:0] ibi_addr = '0;
  logic       ibi_addr_valid = 1'b0;
  logic       bus_available = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;

  target_ibi_sched_if #(.RetryWidth(3)) ibi ();

  target_ibi_sched #(.RetryWidth(3)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .ibi_enable_i     (ibi_enable),
    .ibi_retry_num_i  (ibi_retry_num),
    .ibi_addr_i       (ibi_addr),
    .ibi_addr_valid_i (ibi_addr_valid),
    .bus_available_i  (bus_available),
    .ibi              (ibi.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] all_outs();
    return {ibi.req_ready, ibi.ibi_start, ibi.ibi_addr, ibi.ibi_mdb, ibi.status_valid,
            ibi.status, ibi.retry_cnt, ibi.busy, 6'd0};
  endfunction

  task automatic test_reset();
    ibi.req_valid = 1'b1; ibi.req_mdb = 8'hA5; ibi.fsm_done = 1'b0; ibi.fsm_result = ResAck;
    ibi_enable = 1'b1; ibi_addr_valid = 1'b1; ibi_addr = 7'h11; bus_available = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (all_outs() !== '0) begin
      n_err++; $display("FAIL reset_outputs got %h want 0", all_outs());
    end
    ibi.req_valid = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ibi.busy !== 1'b0) begin
      n_err++; $display("FAIL reset_release_busy got %b want 0", ibi.busy);
    end
  endtask

  // Drives one request end to end; expected outcome comes from walking the result list.
  task automatic run_txn(input int unsigned limit, input logic [6:0] addr, input logic [7:0] mdb,
                         input res_q_t seq, input bit bus_now, input int exp_starts,
                         input string tag);
    int unsigned nacks = 0;
    int starts = 0, k = 0, wait_n, d, v;
    bit fin = 0, got, drop;
    ibi_result_e r;
    ibi_status_e exp_sts = StsOk;
    @(negedge clk);
    ibi.fsm_done = 1'b0; ibi_enable = 1'b1; ibi_addr_valid = 1'b1; ibi_addr = addr;
    ibi_retry_num = 3'(limit); ibi.req_valid = 1'b1; ibi.req_mdb = mdb; bus_available = bus_now;
    #1;
    n_cmp++;
    if (ibi.req_ready !== 1'b1) begin
      n_err++; $display("FAIL %s accept_ready got %b want 1", tag, ibi.req_ready);
    end
    @(negedge clk);
    ibi.req_valid = 1'b0; ibi.req_mdb = 8'($urandom); ibi_addr = 7'($urandom);
    ibi_retry_num = 3'($urandom); ibi_addr_valid = 1'($urandom);
    n_cmp++;
    if (ibi.busy !== 1'b1 || ibi.ibi_start !== 1'b0) begin
      n_err++; $display("FAIL %s after_accept busy/start got %b%b want 10", tag, ibi.busy,
                        ibi.ibi_start);
    end
    while (!fin) begin
      got = 0; wait_n = 0;
      while (!got && wait_n < 40) begin
        @(negedge clk);
        wait_n++;
        ibi.fsm_done = 1'b0;
        if (ibi.status_valid !== 1'b0) begin
          n_cmp++; n_err++; $display("FAIL %s early_status got 1 want 0", tag);
        end
        if (ibi.ibi_start === 1'b1) got = 1;
        else if (!bus_available && ($urandom % 3 == 0)) bus_available = 1'b1;
        else if (!bus_available && ($urandom % 2 == 1)) begin
          ibi.fsm_done = 1'b1; ibi.fsm_result = ResAck;  // must be ignored in WAIT_BUS
        end
      end
      if (!got) begin
        n_cmp++; n_err++; $display("FAIL %s start_timeout got none want start", tag);
        return;
      end
      if (k == 0 && bus_now) begin
        n_cmp++;
        if (wait_n !== 1) begin
          n_err++; $display("FAIL %s start_latency got %0d want 2", tag, wait_n + 1);
        end
      end
      n_cmp++;
      if (ibi.ibi_addr !== addr || ibi.ibi_mdb !== mdb || ibi.retry_cnt !== 3'(nacks)) begin
        n_err++;
        $display("FAIL %s start_fields got %h/%h/%0d want %h/%h/%0d", tag, ibi.ibi_addr,
                 ibi.ibi_mdb, ibi.retry_cnt, addr, mdb, nacks);
      end
      starts++;
      if (k < seq.size()) r = seq[k];
      else if (starts >= 10) r = ResAck;
      else begin
        v = $urandom % 10;
        r = (v < 3) ? ResAck : (v < 7) ? ResNack : (v < 9) ? ResArbLost : ResRsvd;
      end
      k++;
      d = $urandom % 4; drop = 1'($urandom);
      repeat (d) begin
        @(negedge clk);
        if (drop) ibi_enable = 1'b0;
        n_cmp++;
        if (ibi.ibi_start !== 1'b0 || ibi.busy !== 1'b1) begin
          n_err++; $display("FAIL %s wait_result start/busy got %b%b want 01", tag,
                            ibi.ibi_start, ibi.busy);
        end
      end
      @(negedge clk);
      ibi_enable = 1'b1; ibi.fsm_done = 1'b1; ibi.fsm_result = r; bus_available = 1'($urandom);
      if (r == ResAck) fin = 1;
      else if (r != ResArbLost) begin
        if (nacks == limit) begin fin = 1; exp_sts = StsRetryExhausted; end
        else nacks++;
      end
    end
    @(negedge clk);
    ibi.fsm_done = 1'b0;
    n_cmp++;
    if (ibi.status_valid !== 1'b1 || ibi.status !== exp_sts || ibi.retry_cnt !== 3'(nacks)) begin
      n_err++;
      $display("FAIL %s report got v=%b st=%0d cnt=%0d want v=1 st=%0d cnt=%0d", tag,
               ibi.status_valid, ibi.status, ibi.retry_cnt, exp_sts, nacks);
    end
    if (exp_starts != 0) begin
      n_cmp++;
      if (starts !== exp_starts) begin
        n_err++; $display("FAIL %s start_count got %0d want %0d", tag, starts, exp_starts);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (ibi.status_valid !== 1'b0 || ibi.busy !== 1'b0) begin
      n_err++; $display("FAIL %s back_to_idle v/busy got %b%b want 00", tag, ibi.status_valid,
                        ibi.busy);
    end
  endtask

  task automatic test_scenarios();
    res_q_t s;
    s = '{ResNack, ResNack, ResAck};
    run_txn(2, 7'h33, 8'h5C, s, 1'b1, 3, "nack_nack_ack");
    s = '{ResNack, ResNack};
    run_txn(1, 7'h12, 8'hC3, s, 1'b1, 2, "retry_exhausted");
    s = '{ResArbLost, ResArbLost, ResArbLost, ResAck};
    run_txn(0, 7'h45, 8'h01, s, 1'b1, 4, "arb_lost");
    s = '{ResRsvd};
    run_txn(0, 7'h7F, 8'hFF, s, 1'b0, 1, "rsvd_limit0");
  endtask

  task automatic test_abort();
    int starts = 0;
    @(negedge clk);
    ibi_enable = 1'b1; ibi_addr_valid = 1'b1; ibi_addr = 7'h21; bus_available = 1'b0;
    ibi.req_valid = 1'b1; ibi.req_mdb = 8'h77;
    @(negedge clk);
    ibi.req_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (ibi.ibi_start === 1'b1) starts++;
    end
    ibi_enable = 1'b0; bus_available = 1'b1;  // disable wins over bus-available
    @(negedge clk);
    if (ibi.ibi_start === 1'b1) starts++;
    n_cmp++;
    if (ibi.status_valid !== 1'b1 || ibi.status !== StsAborted) begin
      n_err++; $display("FAIL abort_status got v=%b st=%0d want v=1 st=2", ibi.status_valid,
                        ibi.status);
    end
    @(negedge clk);
    ibi_enable = 1'b1;
    if (ibi.ibi_start === 1'b1) starts++;
    n_cmp++;
    if (starts !== 0 || ibi.busy !== 1'b0) begin
      n_err++; $display("FAIL abort_no_start starts/busy got %0d/%b want 0/0", starts, ibi.busy);
    end
  endtask

  task automatic test_addr_valid_gate();
    res_q_t s;
    @(negedge clk);
    ibi_enable = 1'b1; ibi_addr_valid = 1'b0; ibi.req_valid = 1'b1; ibi_addr = 7'h2A;
    #1;
    n_cmp++;
    if (ibi.req_ready !== 1'b0) begin
      n_err++; $display("FAIL gate_ready got %b want 0", ibi.req_ready);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ibi.busy !== 1'b0) begin
      n_err++; $display("FAIL gate_no_accept busy got %b want 0", ibi.busy);
    end
    s = '{ResAck};
    run_txn(0, 7'h2A, 8'h9E, s, 1'b1, 1, "addr_2a");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int bad = 0;
    @(negedge clk);
    ibi_enable = 1'b1; ibi_addr_valid = 1'b1; ibi_addr = 7'h55; bus_available = 1'b1;
    ibi.req_valid = 1'b1; ibi.req_mdb = 8'h3C; ibi_retry_num = 3'd2;
    @(negedge clk);
    ibi.req_valid = 1'b0;
    while (ibi.ibi_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    ibi.req_valid = 1'b1;
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if (all_outs() !== '0) begin
      n_err++; $display("FAIL reset_mid_outputs got %h want 0", all_outs());
    end
    @(negedge clk);
    ibi.req_valid = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1; ibi.fsm_done = 1'b1; ibi.fsm_result = ResAck;
    repeat (5) begin
      @(negedge clk);
      ibi.fsm_done = 1'b0;
      if (ibi.status_valid !== 1'b0 || ibi.busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++; $display("FAIL reset_mid_no_status got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_random();
    res_q_t none;
    for (int i = 0; i < 25; i++) begin
      run_txn($urandom % 8, 7'($urandom), 8'($urandom), none, 1'($urandom), 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_scenarios();
    test_abort();
    test_addr_valid_gate();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got hang want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/target_ibi_sched.md
TARGET_IBI_SCHED -- requirements
Module: target_ibi_sched

Interface
REQ-001 Parameter RetryWidth, default 3, width of retry limit and retry counter.
REQ-002 clk_i  input  1  sole clock; all state on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 ibi_enable_i  input  1  IBI enable from the CSR configuration stage.
REQ-005 ibi_retry_num_i  input  RetryWidth  max NACK retries after the first attempt.
REQ-006 ibi_addr_i  input  7  effective IBI address (dynamic if valid, else static).
REQ-007 ibi_addr_valid_i  input  1  ibi_addr_i usable.
REQ-008 req_valid_i  input  1  TTI IBI request pending.
REQ-009 req_mdb_i  input  8  mandatory data byte of the request.
REQ-010 req_ready_o  output  1  request accepted when req_valid_i & req_ready_o.
REQ-011 bus_available_i  input  1  level from the bus timers: bus-available condition met.
REQ-012 ibi_start_o  output  1  one-cycle pulse to the target FSM: drive IBI now.
REQ-013 ibi_addr_o / ibi_mdb_o  output  7 / 8  latched address and MDB, stable while busy_o.
REQ-014 fsm_done_i  input  1  one-cycle pulse: attempt finished.
REQ-015 fsm_result_i  input  2  00 ACK, 01 NACK, 10 ARB_LOST, 11 reserved; valid with fsm_done_i.
REQ-016 status_valid_o  output  1  one-cycle completion pulse.
REQ-017 status_o  output  2  00 OK, 01 RETRY_EXHAUSTED, 10 ABORTED; valid with status_valid_o.
REQ-018 retry_cnt_o  output  RetryWidth  NACKs consumed for the current request.
REQ-019 busy_o  output  1  high in every state except IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, WAIT_BUS, REQUEST, WAIT_RESULT, REPORT.
REQ-021 req_ready_o SHALL be high only in IDLE and only when ibi_enable_i & ibi_addr_valid_i.
REQ-022 On accept, the block SHALL latch addr, MDB and ibi_retry_num_i, clear retry_cnt_o, and enter WAIT_BUS next cycle.
REQ-023 Changes to the configuration inputs after accept SHALL NOT affect the request in flight.
REQ-024 WAIT_BUS & bus_available_i SHALL go to REQUEST; REQUEST SHALL assert ibi_start_o for exactly one cycle, then go to WAIT_RESULT.
REQ-025 WAIT_BUS & !ibi_enable_i SHALL go to REPORT with ABORTED; disable has priority over bus_available_i in the same cycle.
REQ-026 In WAIT_RESULT, disable SHALL be ignored until fsm_done_i.
REQ-027 fsm_done_i with ACK SHALL go to REPORT with OK.
REQ-028 NACK or reserved result with retry_cnt_o < latched limit SHALL increment retry_cnt_o and return to WAIT_BUS.
REQ-029 NACK or reserved result with retry_cnt_o == latched limit SHALL go to REPORT with RETRY_EXHAUSTED; a limit of 0 means a single attempt.
REQ-030 ARB_LOST SHALL return to WAIT_BUS without changing retry_cnt_o.
REQ-031 REPORT SHALL last one cycle, pulse status_valid_o, then return to IDLE; a new accept is earliest the cycle after.
REQ-032 fsm_done_i outside WAIT_RESULT SHALL be ignored.
REQ-033 Accept-to-ibi_start_o latency SHALL be 2 cycles when bus_available_i is already high.

Reset
REQ-034 While rst_ni is low, the FSM SHALL be in IDLE.
REQ-035 While rst_ni is low, all outputs SHALL be 0, including ibi_addr_o, ibi_mdb_o and retry_cnt_o.
REQ-036 Reset mid-operation SHALL drop the request without a status pulse.

Structure
REQ-037 The result and status encodings SHALL be enums in the shared i3c package.
REQ-038 The FSM state type SHALL be local to the module.
REQ-039 The block SHALL be a single module with no sub-modules.

Verification
REQ-040 Scenario: limit 2, bus available, results NACK, NACK, ACK -> three ibi_start_o pulses, then status OK with retry_cnt_o=2.
REQ-041 Scenario: limit 1, results NACK, NACK -> two starts, then status 01 with retry_cnt_o=1.
REQ-042 Scenario: limit 0, results ARB_LOST ×3 then ACK -> four starts, retry_cnt_o stays 0, then status OK.
REQ-043 Scenario: bus_available_i low, request accepted, ibi_enable_i dropped -> status 10, no ibi_start_o.
REQ-044 Scenario: ibi_addr_valid_i=0 with req_valid_i=1 -> req_ready_o=0 and no accept. Then set valid with addr 0x2A -> accept, and ibi_addr_o=0x2A two cycles later with the start pulse.
REQ-045 Scenario: assert rst_ni low in WAIT_RESULT -> all outputs 0 immediately, and no status_valid_o after release.
